imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_word_assembler.sv | 50 +++++
 rtl/imem_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the boot-time instruction-memory loader.
//   - state_t      : loader FSM states
//   - BytesPerWord : bytes assembled into one instruction word
//   - HeaderBytes  : length-field bytes at the head of a frame
//   - is_rx_state  : true for states that accept bytes and run the idle timer
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int BytesPerWord = 4;
  localparam int HeaderBytes  = 2;
  localparam int ByteCntW     = $clog2(BytesPerWord);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  // States in which the loader is waiting on the byte source. These are
  // exactly the states with rx_ready high and with the idle timer running.
  function automatic logic is_rx_state(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage : imem_loader_pkg

// File: rtl/imem_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_word_assembler
//   Collects bytes into a little-endian instruction word: the first byte of a
//   word lands in bits [7:0], the last in the top byte lane.
//
//   Ports
//     clk_i         clock
//     rst_ni        asynchronous active-low reset
//     clear_i       restart at byte lane 0 (frame start / data phase start)
//     byte_valid_i  a data byte is being accepted this cycle
//     byte_i        the byte being accepted
//     word_o        word under assembly; complete the cycle after word_done_o
//     word_done_o   this cycle's byte completes the word (combinational)
// -----------------------------------------------------------------------------
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        byte_valid_i,
  input  logic [7:0]                  byte_i,
  output logic [8*BytesPerWord-1:0]   word_o,
  output logic                        word_done_o
);

  logic [ByteCntW-1:0]       r_byte_cnt;
  logic [8*BytesPerWord-1:0] r_word;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (clear_i) begin
      r_byte_cnt <= '0;
    end else if (byte_valid_i) begin
      // Every lane is overwritten before a word is used, so the word
      // register itself never needs clearing between words.
      r_word[8*r_byte_cnt +: 8] <= byte_i;
      // Lane counter wraps naturally back to 0 after the last lane.
      r_byte_cnt <= r_byte_cnt + ByteCntW'(1);
    end
  end

  assign word_o      = r_word;
  assign word_done_o = byte_valid_i && (r_byte_cnt == ByteCntW'(BytesPerWord - 1));

endmodule : imem_word_assembler

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction-memory loader. Receives a framed byte stream
//     LEN_LO, LEN_HI, 4*N data bytes (little-endian words), checksum
//   over a valid/ready handshake, writes the words to consecutive word
//   addresses starting at 0, and holds the core in reset until a frame with
//   a matching checksum (sum mod 256 of the data bytes) has loaded.
//
//   Ports
//     clk_i           clock
//     rst_ni          asynchronous active-low reset
//     start_i         single-cycle pulse, begins a frame (ignored while busy)
//     rx_data_i       incoming byte
//     rx_valid_i      byte valid
//     rx_ready_o      loader accepts a byte (registered, state only)
//     imem_ld_o       instruction-memory write strobe, one cycle per word
//     imem_ld_addr_o  word address of the write
//     imem_ld_data_o  instruction word of the write
//     cpu_rst_o       active-high core reset, low only after a good load
//     busy_o          frame in progress
//     done_o          last frame loaded OK (sticky until next start)
//     err_o           last frame failed (sticky until next start)
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AddressWidth  = 10,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  output logic                    imem_ld_o,
  output logic [AddressWidth-1:0] imem_ld_addr_o,
  output logic [DataWidth-1:0]    imem_ld_data_o,
  output logic                    cpu_rst_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int TimeoutW = $clog2(TimeoutCycles + 1);
  // Remaining-word counter must hold 2**AddressWidth itself.
  localparam int RemW     = AddressWidth + 1;
  localparam logic [16:0] MaxWords = 17'(1) << AddressWidth;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_next_state;

  logic [7:0]              r_len_lo;
  logic [RemW-1:0]         r_remaining;
  logic [AddressWidth-1:0] r_word_addr;
  logic [7:0]              r_csum;
  logic [TimeoutW-1:0]     r_timeout;

  logic                    r_rx_ready;
  logic                    r_imem_ld;
  logic                    r_cpu_rst;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic                    w_xfer;
  logic                    w_start;
  logic                    w_timeout;
  logic [15:0]             w_len;
  logic                    w_asm_clear;
  logic                    w_asm_valid;
  logic                    w_word_done;
  logic [8*BytesPerWord-1:0] w_word;

  // A byte moves only when the registered ready is high; ready never looks
  // at rx_valid_i, so there is no combinational path back to the source.
  assign w_xfer = rx_valid_i & r_rx_ready;

  // start_i only acts while no frame is in progress.
  assign w_start = start_i && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));

  // Full 16-bit length as seen in LEN_HI, with the high byte still on the bus.
  assign w_len = {rx_data_i, r_len_lo};

  // Fires on the TimeoutCycles-th consecutive cycle without a transfer.
  assign w_timeout = is_rx_state(r_state) && !w_xfer &&
                     (r_timeout == TimeoutW'(TimeoutCycles - 1));

  // ---------------------------------------------------------------------------
  // Word assembly
  // ---------------------------------------------------------------------------
  assign w_asm_clear = w_start || ((r_state == LEN_HI) && w_xfer);
  assign w_asm_valid = (r_state == DATA) && w_xfer;

  imem_word_assembler u_word_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (w_asm_clear),
    .byte_valid_i (w_asm_valid),
    .byte_i       (rx_data_i),
    .word_o       (w_word),
    .word_done_o  (w_word_done)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start_i) w_next_state = LEN_LO;
      end
      LEN_LO: begin
        if (w_timeout)   w_next_state = ERR;
        else if (w_xfer) w_next_state = LEN_HI;
      end
      LEN_HI: begin
        if (w_timeout) begin
          w_next_state = ERR;
        end else if (w_xfer) begin
          if (w_len == 16'd0)                  w_next_state = CHECK;
          else if ({1'b0, w_len} > MaxWords)   w_next_state = ERR;
          else                                 w_next_state = DATA;
        end
      end
      DATA: begin
        if (w_timeout)        w_next_state = ERR;
        else if (w_word_done) w_next_state = WRITE;
      end
      WRITE: begin
        if (r_remaining == RemW'(1)) w_next_state = CHECK;
        else                         w_next_state = DATA;
      end
      CHECK: begin
        if (w_timeout) begin
          w_next_state = ERR;
        end else if (w_xfer) begin
          if (rx_data_i == r_csum) w_next_state = DONE;
          else                     w_next_state = ERR;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and registered outputs. Outputs are decoded from the next
  // state so they line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_rx_ready <= 1'b0;
      r_imem_ld  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_rx_ready <= is_rx_state(w_next_state);
      r_imem_ld  <= (w_next_state == WRITE);
      r_busy     <= is_rx_state(w_next_state) || (w_next_state == WRITE);
      r_done     <= (w_next_state == DONE);
      r_err      <= (w_next_state == ERR);
      // The core only runs after a clean load; any new start re-holds it.
      r_cpu_rst  <= (w_next_state != DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Length, address, checksum and idle-timeout datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len_lo    <= '0;
      r_remaining <= '0;
      r_word_addr <= '0;
      r_csum      <= '0;
      r_timeout   <= '0;
    end else begin
      if (w_start) begin
        r_csum <= '0;
      end else if ((r_state == DATA) && w_xfer) begin
        r_csum <= r_csum + rx_data_i;
      end

      if ((r_state == LEN_LO) && w_xfer) begin
        r_len_lo <= rx_data_i;
      end

      if ((r_state == LEN_HI) && w_xfer) begin
        // Only meaningful when the length is in range; otherwise the FSM
        // leaves for CHECK or ERR and these values are never used.
        r_remaining <= w_len[RemW-1:0];
        r_word_addr <= '0;
      end else if (r_state == WRITE) begin
        // A full-size frame wraps the address back to 0 after its last word.
        r_remaining <= r_remaining - RemW'(1);
        r_word_addr <= r_word_addr + AddressWidth'(1);
      end

      // The timer only counts while waiting on the byte source; any transfer
      // or any other state restarts it.
      if (!is_rx_state(r_state) || w_xfer) begin
        r_timeout <= '0;
      end else begin
        r_timeout <= r_timeout + TimeoutW'(1);
      end
    end
  end

  assign rx_ready_o     = r_rx_ready;
  assign imem_ld_o      = r_imem_ld;
  assign imem_ld_addr_o = r_word_addr;
  assign imem_ld_data_o = w_word;
  assign cpu_rst_o      = r_cpu_rst;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_o          = r_err;

endmodule : imem_loader
